branch_resolve_tracker: RTL and testbench

- In-order tracker for in-flight predicted branches, sitting between the IF-stage predictor and the MEM-stage branch resolution logic.
- IF pushes each predicted branch: PHT index, predicted direction, PC. MEM resolves branches in program order.
- On each resolution the block drives the predictor's training inputs and issues a mispredict redirect plus a wrong-path squash.
- It also keeps branch and mispredict statistics.

---
 rtl/bp_pkg.sv | 20 ++
 rtl/bp_track_fifo.sv | 64 ++++++
 rtl/branch_resolve_tracker.sv | 142 ++++++++++++++
 tb/tb_branch_resolve_tracker.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared types for the branch resolve tracker: tracked-entry layout
// and the fall-through PC helper.
package bp_pkg;

    localparam int IDX_W = 6;
    localparam int XLEN  = 32;

    typedef struct packed {
        logic [IDX_W-1:0] pht_idx;
        logic             pred_taken;
        logic [XLEN-1:0]  pc;
    } bp_entry_t;

    function automatic logic [XLEN-1:0] fall_through_pc(
        input logic [XLEN-1:0] pc
    );
        return pc + XLEN'(4);
    endfunction

endpackage

// File: rtl/bp_track_fifo.sv
// In-order store of predicted branches awaiting resolution, with a
// single-cycle clear used when the younger entries turn out wrong-path.
module bp_track_fifo
    import bp_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk_i,
    input  logic      rst_i,
    input  logic      push_i,
    input  logic      pop_i,
    input  logic      clear_i,
    input  bp_entry_t din_i,
    output bp_entry_t head_o,
    output logic      full_o,
    output logic      empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0] wr_q, wr_d;
    logic [PW-1:0] rd_q, rd_d;
    bp_entry_t     mem_q [DEPTH];
    bp_entry_t     mem_d [DEPTH];
    logic          do_push;
    logic          do_pop;

    // Extra pointer MSB separates full (MSBs differ) from empty.
    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[AW-1:0] == rd_q[AW-1:0]) &&
                     (wr_q[AW] != rd_q[AW]);
    assign head_o  = mem_q[rd_q[AW-1:0]];

    always_comb begin
        do_push = push_i && !full_o && !clear_i;
        do_pop  = pop_i && !empty_o && !clear_i;
        wr_d    = wr_q + {{AW{1'b0}}, do_push};
        rd_d    = rd_q + {{AW{1'b0}}, do_pop};
        mem_d   = mem_q;
        if (do_push) begin
            mem_d[wr_q[AW-1:0]] = din_i;
        end
        if (clear_i) begin
            wr_d = '0;
            rd_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/branch_resolve_tracker.sv
// Tracks predicted branches from IF until MEM resolves them, then drives
// predictor training, mispredict redirect and branch statistics.
module branch_resolve_tracker #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32,
    parameter int IDX_W = 6,
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_valid_i,
    output logic             push_ready_o,
    input  logic [IDX_W-1:0] push_pht_idx_i,
    input  logic             push_pred_taken_i,
    input  logic [XLEN-1:0]  push_pc_i,
    input  logic             resolve_valid_i,
    input  logic             resolve_taken_i,
    input  logic [XLEN-1:0]  resolve_target_i,
    input  logic             flush_i,
    output logic             upd_valid_o,
    output logic             upd_taken_o,
    output logic [IDX_W-1:0] upd_pht_idx_o,
    output logic             redirect_valid_o,
    output logic [XLEN-1:0]  redirect_pc_o,
    output logic             empty_o,
    output logic             err_o,
    output logic [CNT_W-1:0] branch_cnt_o,
    output logic [CNT_W-1:0] mispred_cnt_o
);

    import bp_pkg::*;

    bp_entry_t push_entry;
    bp_entry_t head;
    logic      fifo_full;
    logic      fifo_empty;
    logic      fifo_push;
    logic      fifo_pop;
    logic      fifo_clear;
    logic      resolve_fire;
    logic      mispred;

    logic             upd_valid_q, upd_valid_d;
    logic             upd_taken_q, upd_taken_d;
    logic [IDX_W-1:0] upd_idx_q, upd_idx_d;
    logic             redir_valid_q, redir_valid_d;
    logic [XLEN-1:0]  redir_pc_q, redir_pc_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
    logic [CNT_W-1:0] mispred_cnt_q, mispred_cnt_d;

    assign push_entry.pht_idx    = push_pht_idx_i;
    assign push_entry.pred_taken = push_pred_taken_i;
    assign push_entry.pc         = push_pc_i;

    bp_track_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .clear_i (fifo_clear),
        .din_i   (push_entry),
        .head_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        resolve_fire = resolve_valid_i && !fifo_empty;
        mispred      = resolve_fire &&
                       (head.pred_taken != resolve_taken_i);
        push_ready_o = !fifo_full;
        // A mispredict makes the incoming push wrong-path as well.
        fifo_push    = push_valid_i && push_ready_o &&
                       !flush_i && !mispred;
        fifo_pop     = resolve_fire;
        fifo_clear   = flush_i || mispred;
    end

    always_comb begin
        upd_valid_d   = resolve_fire;
        upd_taken_d   = 1'b0;
        upd_idx_d     = '0;
        redir_valid_d = mispred && !flush_i;
        redir_pc_d    = '0;
        err_d         = err_q || (resolve_valid_i && fifo_empty);
        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        if (resolve_fire) begin
            upd_taken_d = resolve_taken_i;
            upd_idx_d   = head.pht_idx;
            if (branch_cnt_q != '1) begin
                branch_cnt_d = branch_cnt_q + CNT_W'(1);
            end
        end
        if (mispred) begin
            redir_pc_d = resolve_taken_i ? resolve_target_i
                                         : fall_through_pc(head.pc);
            if (mispred_cnt_q != '1) begin
                mispred_cnt_d = mispred_cnt_q + CNT_W'(1);
            end
        end
        if (!redir_valid_d) begin
            redir_pc_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            upd_valid_q   <= 1'b0;
            upd_taken_q   <= 1'b0;
            upd_idx_q     <= '0;
            redir_valid_q <= 1'b0;
            redir_pc_q    <= '0;
            err_q         <= 1'b0;
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            upd_valid_q   <= upd_valid_d;
            upd_taken_q   <= upd_taken_d;
            upd_idx_q     <= upd_idx_d;
            redir_valid_q <= redir_valid_d;
            redir_pc_q    <= redir_pc_d;
            err_q         <= err_d;
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign upd_valid_o      = upd_valid_q;
    assign upd_taken_o      = upd_taken_q;
    assign upd_pht_idx_o    = upd_idx_q;
    assign redirect_valid_o = redir_valid_q;
    assign redirect_pc_o    = redir_pc_q;
    assign empty_o          = fifo_empty;
    assign err_o            = err_q;
    assign branch_cnt_o     = branch_cnt_q;
    assign mispred_cnt_o    = mispred_cnt_q;

endmodule

// File: tb/tb_branch_resolve_tracker.sv
// Directed bench for branch_resolve_tracker (DEPTH=4, CNT_W=4 so the
// saturating counters can be reached quickly).
module tb_branch_resolve_tracker;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        push_valid = 1'b0;
    logic        push_ready;
    logic [5:0]  push_idx = '0;
    logic        push_pred = 1'b0;
    logic [31:0] push_pc = '0;
    logic        res_valid = 1'b0;
    logic        res_taken = 1'b0;
    logic [31:0] res_target = '0;
    logic        flush = 1'b0;
    logic        upd_valid;
    logic        upd_taken;
    logic [5:0]  upd_idx;
    logic        redir_valid;
    logic [31:0] redir_pc;
    logic        empty;
    logic        err;
    logic [3:0]  branch_cnt;
    logic [3:0]  mispred_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    branch_resolve_tracker #(
        .DEPTH (4),
        .XLEN  (32),
        .IDX_W (6),
        .CNT_W (4)
    ) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .push_valid_i      (push_valid),
        .push_ready_o      (push_ready),
        .push_pht_idx_i    (push_idx),
        .push_pred_taken_i (push_pred),
        .push_pc_i         (push_pc),
        .resolve_valid_i   (res_valid),
        .resolve_taken_i   (res_taken),
        .resolve_target_i  (res_target),
        .flush_i           (flush),
        .upd_valid_o       (upd_valid),
        .upd_taken_o       (upd_taken),
        .upd_pht_idx_o     (upd_idx),
        .redirect_valid_o  (redir_valid),
        .redirect_pc_o     (redir_pc),
        .empty_o           (empty),
        .err_o             (err),
        .branch_cnt_o      (branch_cnt),
        .mispred_cnt_o     (mispred_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        push_valid = 1'b0;
        res_valid  = 1'b0;
        flush      = 1'b0;
        rst        = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic push(input logic [5:0] idx, input logic pred,
                        input logic [31:0] pc);
        push_valid = 1'b1;
        push_idx   = idx;
        push_pred  = pred;
        push_pc    = pc;
    endtask

    task automatic resolve(input logic taken, input logic [31:0] tgt);
        res_valid  = 1'b1;
        res_taken  = taken;
        res_target = tgt;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (empty !== 1'b1) begin
            errors++;
            $display("FAIL rst_empty got %b exp 1", empty);
        end
        checks++;
        if (push_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_ready got %b exp 1", push_ready);
        end
        checks++;
        if ({upd_valid, redir_valid, err} !== 3'b000) begin
            errors++;
            $display("FAIL rst_flags got %b exp 000",
                     {upd_valid, redir_valid, err});
        end
        checks++;
        if ({branch_cnt, mispred_cnt} !== 8'h00) begin
            errors++;
            $display("FAIL rst_cnt got %h exp 00",
                     {branch_cnt, mispred_cnt});
        end
    endtask

    task automatic test_correct();
        do_reset();
        push(6'd5, 1'b0, 32'h100);
        tick();
        idle();
        resolve(1'b0, 32'h0);
        tick();
        idle();
        checks++;
        if ({upd_valid, upd_taken, upd_idx} !== {1'b1, 1'b0, 6'd5}) begin
            errors++;
            $display("FAIL corr_upd got v%b t%b i%0d exp v1 t0 i5",
                     upd_valid, upd_taken, upd_idx);
        end
        checks++;
        if (redir_valid !== 1'b0) begin
            errors++;
            $display("FAIL corr_redir got %b exp 0", redir_valid);
        end
        checks++;
        if (branch_cnt !== 4'd1 || mispred_cnt !== 4'd0) begin
            errors++;
            $display("FAIL corr_cnt got %0d/%0d exp 1/0",
                     branch_cnt, mispred_cnt);
        end
        checks++;
        if (empty !== 1'b1) begin
            errors++;
            $display("FAIL corr_empty got %b exp 1", empty);
        end
        tick();
        checks++;
        if (upd_valid !== 1'b0) begin
            errors++;
            $display("FAIL corr_pulse got %b exp 0", upd_valid);
        end
    endtask

    task automatic test_mispredict();
        do_reset();
        push(6'd9, 1'b0, 32'h200);
        tick();
        idle();
        resolve(1'b1, 32'h380);
        tick();
        idle();
        checks++;
        if (redir_valid !== 1'b1 || redir_pc !== 32'h380) begin
            errors++;
            $display("FAIL mis_taken got v%b pc%h exp v1 pc00000380",
                     redir_valid, redir_pc);
        end
        checks++;
        if (upd_idx !== 6'd9 || upd_taken !== 1'b1) begin
            errors++;
            $display("FAIL mis_upd got i%0d t%b exp i9 t1",
                     upd_idx, upd_taken);
        end
        checks++;
        if (mispred_cnt !== 4'd1) begin
            errors++;
            $display("FAIL mis_cnt1 got %0d exp 1", mispred_cnt);
        end
        push(6'd12, 1'b1, 32'h200);
        tick();
        idle();
        resolve(1'b0, 32'h999);
        tick();
        idle();
        checks++;
        if (redir_valid !== 1'b1 || redir_pc !== 32'h204) begin
            errors++;
            $display("FAIL mis_fall got v%b pc%h exp v1 pc00000204",
                     redir_valid, redir_pc);
        end
        checks++;
        if (mispred_cnt !== 4'd2 || branch_cnt !== 4'd2) begin
            errors++;
            $display("FAIL mis_cnt2 got %0d/%0d exp 2/2",
                     branch_cnt, mispred_cnt);
        end
        tick();
        checks++;
        if (redir_valid !== 1'b0) begin
            errors++;
            $display("FAIL mis_pulse got %b exp 0", redir_valid);
        end
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            push(6'(i), 1'b0, 32'h1000 + 32'(i) * 4);
            tick();
        end
        idle();
        checks++;
        if (push_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_ready got %b exp 0", push_ready);
        end
        push(6'd7, 1'b0, 32'h2000);
        tick();
        idle();
        for (int i = 1; i <= 4; i++) begin
            resolve(1'b0, 32'h0);
            tick();
            idle();
            checks++;
            if (upd_valid !== 1'b1 || upd_idx !== 6'(i)) begin
                errors++;
                $display("FAIL full_drain%0d got v%b i%0d exp v1 i%0d",
                         i, upd_valid, upd_idx, i);
            end
        end
        checks++;
        if (empty !== 1'b1) begin
            errors++;
            $display("FAIL full_dropped got empty=%b exp 1", empty);
        end
        for (int i = 1; i <= 4; i++) begin
            push(6'(i), 1'b0, 32'h3000);
            tick();
        end
        idle();
        resolve(1'b1, 32'h500);
        push(6'd8, 1'b0, 32'h4000);
        tick();
        idle();
        checks++;
        if (empty !== 1'b1 || push_ready !== 1'b1) begin
            errors++;
            $display("FAIL full_squash got e%b r%b exp e1 r1",
                     empty, push_ready);
        end
        checks++;
        if (redir_valid !== 1'b1 || redir_pc !== 32'h500) begin
            errors++;
            $display("FAIL full_redir got v%b pc%h exp v1 pc00000500",
                     redir_valid, redir_pc);
        end
        push(6'd11, 1'b0, 32'h10);
        tick();
        idle();
        resolve(1'b1, 32'h600);
        push(6'd13, 1'b0, 32'h20);
        tick();
        idle();
        checks++;
        if (empty !== 1'b1) begin
            errors++;
            $display("FAIL mis_push_drop got empty=%b exp 1", empty);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        push(6'd20, 1'b0, 32'h0);
        tick();
        for (int i = 0; i < 10; i++) begin
            push(6'(21 + i), 1'b0, 32'(i) * 4);
            resolve(1'b0, 32'h0);
            tick();
            checks++;
            if (upd_valid !== 1'b1 || upd_idx !== 6'(20 + i) ||
                empty !== 1'b0) begin
                errors++;
                $display("FAIL b2b%0d got v%b i%0d e%b exp v1 i%0d e0",
                         i, upd_valid, upd_idx, empty, 20 + i);
            end
        end
        idle();
        resolve(1'b0, 32'h0);
        tick();
        idle();
        checks++;
        if (upd_idx !== 6'd30 || empty !== 1'b1) begin
            errors++;
            $display("FAIL b2b_last got i%0d e%b exp i30 e1",
                     upd_idx, empty);
        end
        checks++;
        if (branch_cnt !== 4'd11) begin
            errors++;
            $display("FAIL b2b_cnt got %0d exp 11", branch_cnt);
        end
    endtask

    task automatic test_err_flush();
        do_reset();
        resolve(1'b1, 32'h0);
        tick();
        idle();
        checks++;
        if (err !== 1'b1 || upd_valid !== 1'b0 || branch_cnt !== 4'd0) begin
            errors++;
            $display("FAIL err_set got e%b u%b c%0d exp e1 u0 c0",
                     err, upd_valid, branch_cnt);
        end
        tick();
        tick();
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL err_sticky got %b exp 1", err);
        end
        for (int i = 1; i <= 3; i++) begin
            push(6'(i), 1'b0, 32'h40);
            tick();
        end
        idle();
        flush = 1'b1;
        resolve(1'b1, 32'h700);
        tick();
        idle();
        checks++;
        if (upd_valid !== 1'b1 || upd_idx !== 6'd1) begin
            errors++;
            $display("FAIL flush_upd got v%b i%0d exp v1 i1",
                     upd_valid, upd_idx);
        end
        checks++;
        if (redir_valid !== 1'b0 || empty !== 1'b1) begin
            errors++;
            $display("FAIL flush_redir got r%b e%b exp r0 e1",
                     redir_valid, empty);
        end
        checks++;
        if (branch_cnt !== 4'd1 || mispred_cnt !== 4'd1) begin
            errors++;
            $display("FAIL flush_cnt got %0d/%0d exp 1/1",
                     branch_cnt, mispred_cnt);
        end
    endtask

    task automatic test_saturate_reset();
        do_reset();
        for (int i = 1; i <= 17; i++) begin
            push(6'(i), 1'b0, 32'h80);
            tick();
            idle();
            resolve(1'b1, 32'h90);
            tick();
            idle();
            if (i == 15 || i == 17) begin
                checks++;
                if (mispred_cnt !== 4'hF || branch_cnt !== 4'hF) begin
                    errors++;
                    $display("FAIL sat%0d got %h/%h exp F/F",
                             i, branch_cnt, mispred_cnt);
                end
            end
        end
        push(6'd3, 1'b0, 32'h80);
        tick();
        idle();
        resolve(1'b1, 32'h90);
        rst = 1'b1;
        tick();
        idle();
        checks++;
        if (upd_valid !== 1'b0 || redir_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_pulse got u%b r%b exp u0 r0",
                     upd_valid, redir_valid);
        end
        checks++;
        if ({branch_cnt, mispred_cnt} !== 8'h00 || empty !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_state got c%h e%b exp c00 e1",
                     {branch_cnt, mispred_cnt}, empty);
        end
        tick();
        checks++;
        if (upd_valid !== 1'b0 || redir_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_late got u%b r%b exp u0 r0",
                     upd_valid, redir_valid);
        end
    endtask

    initial begin
        test_reset();
        test_correct();
        test_mispredict();
        test_full();
        test_back_to_back();
        test_err_flush();
        test_saturate_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
